// File: rtl/bidirectional_counter.sv
// rtl/bidirectional_counter.sv - free-running up/down modulo counter with terminal flags and wrap pulse
module bidirectional_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up_down,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] COUNT_MIN = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] COUNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_next;
  logic             wrap_next;

  // Wrap is detected from the value being left, so it needs no carry/borrow bit.
  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    if (up_down) begin
      count_next = count + COUNT_ONE;
      wrap_next  = (count == COUNT_MAX);
    end else begin
      count_next = count - COUNT_ONE;
      wrap_next  = (count == COUNT_MIN);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= COUNT_MIN;
      wrap  <= 1'b0;
    end else begin
      count <= count_next;
      wrap  <= wrap_next;
    end
  end

  assign at_max = (count == COUNT_MAX);
  assign at_min = (count == COUNT_MIN);

endmodule

// File: tb/tb_bidirectional_counter.sv
// tb/tb_bidirectional_counter.sv - directed vector bench for bidirectional_counter
module tb_bidirectional_counter;

  logic       clk;
  logic       reset;
  logic       up_down;
  logic [3:0] count;
  logic       at_max;
  logic       at_min;
  logic       wrap;

  int checks;
  int failures;

  typedef struct {
    logic       ud;
    logic [3:0] cnt;
    logic       wr;
    logic       mx;
    logic       mn;
  } vec_t;

  vec_t vecs[$];

  bidirectional_counter #(.WIDTH(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .up_down (up_down),
    .count   (count),
    .at_max  (at_max),
    .at_min  (at_min),
    .wrap    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  task automatic check_state(input string name, input int idx, input logic [3:0] c, input logic w,
                             input logic mx, input logic mn);
    cmp({name, ".count"}, idx, 32'(count), 32'(c));
    cmp({name, ".wrap"}, idx, 32'(wrap), 32'(w));
    cmp({name, ".at_max"}, idx, 32'(at_max), 32'(mx));
    cmp({name, ".at_min"}, idx, 32'(at_min), 32'(mn));
  endtask

  task automatic add_vec(input logic ud, input logic [3:0] cnt, input logic wr, input logic mx, input logic mn);
    vec_t v;
    v.ud  = ud;
    v.cnt = cnt;
    v.wr  = wr;
    v.mx  = mx;
    v.mn  = mn;
    vecs.push_back(v);
  endtask

  task automatic step(input logic ud, input string name, input int idx, input logic [3:0] c,
                      input logic w, input logic mx, input logic mn);
    up_down = ud;
    @(posedge clk);
    #1;
    check_state(name, idx, c, w, mx, mn);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // ud, count, wrap, at_max, at_min
    add_vec(1'b1, 4'd1,  1'b0, 1'b0, 1'b0);
    add_vec(1'b1, 4'd2,  1'b0, 1'b0, 1'b0);
    add_vec(1'b1, 4'd3,  1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 4'd2,  1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 4'd1,  1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 4'd0,  1'b0, 1'b0, 1'b1);
    add_vec(1'b0, 4'd15, 1'b1, 1'b1, 1'b0);
    add_vec(1'b0, 4'd14, 1'b0, 1'b0, 1'b0);
    add_vec(1'b1, 4'd15, 1'b0, 1'b1, 1'b0);
    add_vec(1'b1, 4'd0,  1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 14; k++) add_vec(1'b1, 4'(k), 1'b0, 1'b0, 1'b0);
    add_vec(1'b1, 4'd15, 1'b0, 1'b1, 1'b0);
    add_vec(1'b1, 4'd0,  1'b1, 1'b0, 1'b1);
    add_vec(1'b1, 4'd1,  1'b0, 1'b0, 1'b0);

    reset   = 1'b1;
    up_down = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check_state("async_clear", 0, 4'd0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check_state("reset_hold", 0, 4'd0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check_state("reset_hold", 1, 4'd0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].ud, "vec", i, vecs[i].cnt, vecs[i].wr, vecs[i].mx, vecs[i].mn);
    end

    // Count from 1 up to 7, then drop reset between edges.
    for (int k = 2; k <= 7; k++) step(1'b1, "to_seven", k, 4'(k), 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_state("mid_reset", 0, 4'd0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check_state("mid_reset_hold", 0, 4'd0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    for (int k = 1; k <= 3; k++) step(1'b1, "recount", k, 4'(k), 1'b0, 1'b0, 1'b0);

    // Release into a down edge: 0 -> 15 with wrap, then clear wrap asynchronously.
    reset = 1'b0;
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b0, "release_down", 0, 4'd15, 1'b1, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_state("wrap_clear", 0, 4'd0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bidirectional_counter.md
# bidirectional_counter

Free-running, parameterised up/down binary counter with modulo wrap-around and terminal-value flags. It serves as a general-purpose counting primitive for timers, address stepping and event tallies. Direction is selected per clock by a single control input. It sits directly on the system clock/reset domain with no handshake.

## Interface

**Parameters**
- `WIDTH`, default 4: counter width in bits; legal range 1..32.

**Ports**
- Clocking: one clock; reset is asynchronous and active-low.
- `clk` input, 1 bit: system clock; all state changes on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset; 0 clears all state.
- `up_down` input, 1 bit: direction select; 1 = count up, 0 = count down.
- `count` output, `WIDTH` bits: current counter value, driven directly from a register.
- `at_max` output, 1 bit: combinational, high when `count` == 2^WIDTH−1.
- `at_min` output, 1 bit: combinational, high when `count` == 0.
- `wrap` output, 1 bit: registered, high for exactly one cycle after an edge on which the counter wrapped, in either direction.

## Operation

- Counter is always enabled. Every rising edge of `clk` with `reset` high changes `count`:
  - `up_down`=1: `count` <= `count` + 1 mod 2^WIDTH.
  - `up_down`=0: `count` <= `count` − 1 mod 2^WIDTH.
- Arithmetic is unsigned, `WIDTH` bits. There is no carry or borrow output beyond `wrap`.
- Wrap-around:
  - Counting up from 2^WIDTH−1 gives 0 and sets `wrap` on that edge.
  - Counting down from 0 gives 2^WIDTH−1 and sets `wrap` on that edge.
- `wrap` is 0 after any non-wrapping edge.
- Direction change:
  - `up_down` is sampled at each edge and takes effect on that same edge.
  - No dead cycle; the count does not repeat or skip on reversal.
- `at_max` and `at_min` decode the registered `count` only. They do not depend on `up_down`. With WIDTH=1 both flags toggle alternately.
- Reset (`reset`=0):
  - `count` = 0 and `wrap` = 0 immediately, without waiting for a clock edge.
  - Outputs follow, giving `at_min`=1 and `at_max`=0.
  - Reset dominates clock activity for as long as it is held.
- Reset mid-operation: any in-progress count is discarded. There is no saved state.

## Timing

- Latency: one clock from `up_down` sampling to the updated `count`.
- Flags are valid in the same cycle as the `count` they describe.
- Reset assertion is asynchronous: `count` reads 0 within the same cycle that `reset` falls.
- Reset deassertion:
  - The counter holds 0 until the first rising edge at which `reset` is high.
  - That edge produces 1 (up) or 2^WIDTH−1 (down).
  - `reset` deassertion must meet recovery/removal timing relative to `clk`. Upstream reset synchronisation is the integrator's responsibility.
- `up_down` must meet setup/hold relative to the rising `clk` edge. There is no internal synchroniser.
- No X-propagation tolerance is required on `up_down` while `reset` is low.

## Test plan

All scenarios use WIDTH=4.

1. Hold `reset`=0 for 2 edges, then release. Required: `count`=0, `at_min`=1 and `wrap`=0 during reset. Asynchronous clear is visible before the first edge.
2. Release reset with `up_down`=1, run 3 edges. Required: `count` = 1, 2, 3; `wrap`=0 throughout.
3. From 3, set `up_down`=0, run 3 edges. Required: `count` = 2, 1, 0; `at_min`=1 at 0. Reversal adds no extra cycle.
4. From 0 with `up_down`=0, one edge. Required: `count`=15, `at_max`=1, `wrap`=1 for one cycle. A further down edge gives 14 and `wrap`=0.
5. Count up from 0 through 15. On the next edge: `count`=0 and `wrap`=1 for exactly one cycle, with `at_max` high only while `count`=15.
6. At `count`=7, drop `reset` between clock edges. Required: `count`=0 immediately, asynchronously. Release and re-count up 3 edges: `count` = 1, 2, 3.
